wb_port_arbiter: RTL and testbench

//  Owns the single register-file write port at the write-back stage. Arbitrates between the ALU

---
 rtl/rv_wb_pkg.sv | 34 +++
 rtl/wb_scoreboard.sv | 50 +++++
 rtl/wb_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// Shared types and default sizes for the write-back port arbiter and its scoreboard.
package rv_wb_pkg;

    localparam int XLEN               = 32;
    localparam int REG_AW             = 5;
    localparam int NREGS              = 2 ** REG_AW;
    localparam int STARVE_LIMIT_DFLT  = 4;

    // Which requester currently has priority on the write port.
    typedef enum logic {
        LD_PRI  = 1'b0,
        ALU_PRI = 1'b1
    } wb_state_e;

    // Source of the write granted this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

    // Saturating increment of the starvation counter (values kept in 8 bits
    // here; callers truncate to their own counter width).
    function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] limit);
        logic [7:0] res;
        if (val >= limit) begin
            res = limit;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard: one bit per architectural register, set when decode issues a
// producer for it and cleared when that producer's result is granted the write
// port or when the pipeline is flushed. Register 0 is never busy.
module wb_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [REG_AW-1:0]      set_idx,
    input  logic                   clr_en,
    input  logic [REG_AW-1:0]      clr_idx,
    input  logic                   flush,
    output logic [(2**REG_AW)-1:0] busy_vec
);

    localparam int NREGS = 2 ** REG_AW;

    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_q;

    // Per-register next state: a new issue beats flush, flush beats a write clear.
    always_comb begin
        busy_d = busy_q;
        busy_d[0] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (set_en && (set_idx == REG_AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (flush) begin
                busy_d[r] = 1'b0;
            end else if (clr_en && (clr_idx == REG_AW'(r))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
    end

    // Scoreboard register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: grants at most one of the ALU / load results per
// cycle onto the single register-file write port, registers the write, and
// keeps the busy scoreboard used by decode for hazard checks. Loads normally
// win; an ALU result stalled STARVE_LIMIT cycles in a row is forced through.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [REG_AW-1:0]      alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    output logic                   alu_ready,
    input  logic                   ld_valid,
    input  logic [REG_AW-1:0]      ld_rd,
    input  logic [XLEN-1:0]        ld_data,
    output logic                   ld_ready,
    input  logic                   iss_valid,
    input  logic [REG_AW-1:0]      iss_rd,
    input  logic                   flush,
    output logic                   rf_we,
    output logic [REG_AW-1:0]      rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic [(2**REG_AW)-1:0] busy_vec
);

    import rv_wb_pkg::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);

    wb_state_e          state_d;
    wb_state_e          state_q;
    logic [CNT_W-1:0]   starve_cnt_d;
    logic [CNT_W-1:0]   starve_cnt_q;
    logic               rf_we_d;
    logic               rf_we_q;
    logic [REG_AW-1:0]  rf_waddr_d;
    logic [REG_AW-1:0]  rf_waddr_q;
    logic [XLEN-1:0]    rf_wdata_d;
    logic [XLEN-1:0]    rf_wdata_q;

    wb_src_e            src_s;
    logic               alu_grant_s;
    logic               ld_grant_s;
    logic               alu_stall_s;
    logic               grant_any_s;
    logic [REG_AW-1:0]  grant_rd_s;

    // Grant selection: depends only on priority state and the two valids.
    always_comb begin
        src_s = SRC_NONE;
        if (!rst) begin
            src_s = SRC_NONE;
        end else begin
            case (state_q)
                LD_PRI: begin
                    if (ld_valid) begin
                        src_s = SRC_LD;
                    end else if (alu_valid) begin
                        src_s = SRC_ALU;
                    end else begin
                        src_s = SRC_NONE;
                    end
                end
                ALU_PRI: begin
                    if (alu_valid) begin
                        src_s = SRC_ALU;
                    end else if (ld_valid) begin
                        src_s = SRC_LD;
                    end else begin
                        src_s = SRC_NONE;
                    end
                end
                default: begin
                    src_s = SRC_NONE;
                end
            endcase
        end
    end

    assign alu_grant_s = (src_s == SRC_ALU);
    assign ld_grant_s  = (src_s == SRC_LD);
    assign grant_any_s = alu_grant_s | ld_grant_s;
    assign alu_stall_s = alu_valid & ~alu_grant_s;
    assign grant_rd_s  = alu_grant_s ? alu_rd : ld_rd;

    assign alu_ready = alu_grant_s;
    assign ld_ready  = ld_grant_s;

    // Priority FSM and starvation counter next state.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;

        if (alu_stall_s) begin
            starve_cnt_d = CNT_W'(sat_inc(8'(starve_cnt_q), 8'(CNT_MAX)));
        end else begin
            starve_cnt_d = {CNT_W{1'b0}};
        end

        case (state_q)
            LD_PRI: begin
                if (alu_stall_s && (starve_cnt_q == CNT_TRIP)) begin
                    state_d = ALU_PRI;
                end else begin
                    state_d = LD_PRI;
                end
            end
            ALU_PRI: begin
                // Priority is lent for a single ALU write, or returned as soon
                // as the ALU stops asking for it.
                if (alu_grant_s || !alu_valid) begin
                    state_d = LD_PRI;
                end else begin
                    state_d = ALU_PRI;
                end
            end
            default: begin
                state_d = LD_PRI;
            end
        endcase
    end

    // Next value of the registered write port; address/data hold when idle.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (src_s)
            SRC_ALU: begin
                rf_we_d    = (alu_rd != {REG_AW{1'b0}});
                rf_waddr_d = alu_rd;
                rf_wdata_d = alu_data;
            end
            SRC_LD: begin
                rf_we_d    = (ld_rd != {REG_AW{1'b0}});
                rf_waddr_d = ld_rd;
                rf_wdata_d = ld_data;
            end
            default: begin
                rf_we_d    = 1'b0;
                rf_waddr_d = rf_waddr_q;
                rf_wdata_d = rf_wdata_q;
            end
        endcase
    end

    // State, counter and write-port registers; reset discards any pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= LD_PRI;
            starve_cnt_q <= {CNT_W{1'b0}};
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= {REG_AW{1'b0}};
            rf_wdata_q   <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // A granted write to x0 clears nothing: bit 0 is never set in the scoreboard.
    wb_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_valid),
        .set_idx  (iss_rd),
        .clr_en   (grant_any_s),
        .clr_idx  (grant_rd_s),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_wb_port_arbiter;

    localparam int XLEN         = 32;
    localparam int REG_AW       = 5;
    localparam int NREGS        = 32;
    localparam int STARVE_LIMIT = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                alu_valid;
    logic [REG_AW-1:0]   alu_rd;
    logic [XLEN-1:0]     alu_data;
    logic                alu_ready;
    logic                ld_valid;
    logic [REG_AW-1:0]   ld_rd;
    logic [XLEN-1:0]     ld_data;
    logic                ld_ready;
    logic                iss_valid;
    logic [REG_AW-1:0]   iss_rd;
    logic                flush;
    logic                rf_we;
    logic [REG_AW-1:0]   rf_waddr;
    logic [XLEN-1:0]     rf_wdata;
    logic [NREGS-1:0]    busy_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic                m_we = 1'b0;
    logic [REG_AW-1:0]   m_waddr = '0;
    logic [XLEN-1:0]     m_wdata = '0;
    logic [NREGS-1:0]    m_busy = '0;
    int                  m_run = 0;   // consecutive cycles the ALU has been refused
    logic                exp_alu_g;
    logic                exp_ld_g;
    logic                obs_alu_rdy;
    logic                obs_ld_rdy;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .XLEN(XLEN), .REG_AW(REG_AW), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
    );

    // One clock: sample readies mid-cycle, predict with the model, return after the edge.
    task automatic cycle();
        logic              any_g;
        logic [REG_AW-1:0] w_rd;
        logic [XLEN-1:0]   w_data;
        @(negedge clk);
        obs_alu_rdy = alu_ready;
        obs_ld_rdy  = ld_ready;
        exp_alu_g = 1'b0;
        exp_ld_g  = 1'b0;
        if (rst) begin
            // Loads win unless the ALU has already been refused STARVE_LIMIT times in a row.
            if (alu_valid && (!ld_valid || m_run >= STARVE_LIMIT)) exp_alu_g = 1'b1;
            else if (ld_valid) exp_ld_g = 1'b1;
        end
        any_g  = exp_alu_g | exp_ld_g;
        w_rd   = exp_alu_g ? alu_rd : ld_rd;
        w_data = exp_alu_g ? alu_data : ld_data;
        if (!rst) begin
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_run = 0;
        end else begin
            m_we = any_g && (w_rd != 0);
            if (any_g) begin
                m_waddr = w_rd;
                m_wdata = w_data;
            end
            for (int r = 1; r < NREGS; r++) begin
                if (iss_valid && int'(iss_rd) == r) m_busy[r] = 1'b1;
                else if (flush) m_busy[r] = 1'b0;
                else if (any_g && int'(w_rd) == r) m_busy[r] = 1'b0;
            end
            m_busy[0] = 1'b0;
            if (alu_valid && !exp_alu_g) m_run = (m_run < STARVE_LIMIT) ? m_run + 1 : m_run;
            else m_run = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111;
        ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h2222;
        iss_valid = 1'b1; iss_rd = 5'd3; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (obs_alu_rdy !== 1'b0 || obs_ld_rdy !== 1'b0) begin
                errors++; $display("FAIL reset_ready: got alu=%b ld=%b expected 0 0", obs_alu_rdy, obs_ld_rdy);
            end
            checks++;
            if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin
                errors++; $display("FAIL reset_rf: got we=%b addr=%0d data=%h expected 0 0 0", rf_we, rf_waddr, rf_wdata);
            end
            checks++;
            if (busy_vec !== 32'h0) begin
                errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec);
            end
        end
        rst = 1'b1;
        set_idle();
        cycle();
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        cycle();
        checks++;
        if (obs_alu_rdy !== 1'b1) begin
            errors++; $display("FAIL alu_only_ready: got %b expected 1", obs_alu_rdy);
        end
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            errors++; $display("FAIL alu_only_write: got we=%b addr=%0d data=%h expected 1 5 1234", rf_we, rf_waddr, rf_wdata);
        end
        set_idle();
        cycle();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            errors++; $display("FAIL idle_hold: got we=%b addr=%0d data=%h expected 0 5 1234", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_conflict();
        ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'hAAAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBBBB;
        cycle();
        checks++;
        if (obs_ld_rdy !== 1'b1 || obs_alu_rdy !== 1'b0) begin
            errors++; $display("FAIL conflict_grant1: got ld=%b alu=%b expected 1 0", obs_ld_rdy, obs_alu_rdy);
        end
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAAAA) begin
            errors++; $display("FAIL conflict_write1: got we=%b addr=%0d data=%h expected 1 3 aaaa", rf_we, rf_waddr, rf_wdata);
        end
        ld_valid = 1'b0;
        cycle();
        checks++;
        if (obs_alu_rdy !== 1'b1) begin
            errors++; $display("FAIL conflict_grant2: got alu=%b expected 1", obs_alu_rdy);
        end
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hBBBB) begin
            errors++; $display("FAIL conflict_write2: got we=%b addr=%0d data=%h expected 1 4 bbbb", rf_we, rf_waddr, rf_wdata);
        end
        set_idle();
    endtask

    task automatic test_starvation();
        ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h0000_2222;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h0000_6666;
        for (int i = 0; i < 15; i++) begin
            logic alu_turn;
            alu_turn = ((i % 5) == 4);
            cycle();
            checks++;
            if (obs_alu_rdy !== alu_turn || obs_ld_rdy !== !alu_turn) begin
                errors++; $display("FAIL starve_grant[%0d]: got alu=%b ld=%b expected alu=%b", i, obs_alu_rdy, obs_ld_rdy, alu_turn);
            end
            checks++;
            if (rf_waddr !== (alu_turn ? 5'd6 : 5'd2)) begin
                errors++; $display("FAIL starve_waddr[%0d]: got %0d expected %0d", i, rf_waddr, alu_turn ? 6 : 2);
            end
        end
        set_idle();
        cycle();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        checks++;
        if (busy_vec !== 32'h0000_0080) begin
            errors++; $display("FAIL sb_issue7: got %h expected 00000080", busy_vec);
        end
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777;
        cycle();
        checks++;
        if (busy_vec !== 32'h0000_0080 || rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
            errors++; $display("FAIL sb_set_wins: got busy=%h we=%b addr=%0d expected 00000080 1 7", busy_vec, rf_we, rf_waddr);
        end
        alu_valid = 1'b0; iss_rd = 5'd12;
        cycle();
        checks++;
        if (busy_vec !== 32'h0000_1080) begin
            errors++; $display("FAIL sb_issue12: got %h expected 00001080", busy_vec);
        end
        flush = 1'b1; iss_rd = 5'd9;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h3333;
        cycle();
        checks++;
        if (busy_vec !== 32'h0000_0200 || rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h3333) begin
            errors++; $display("FAIL sb_flush: got busy=%h we=%b addr=%0d data=%h expected 00000200 1 3 3333", busy_vec, rf_we, rf_waddr, rf_wdata);
        end
        flush = 1'b0; ld_valid = 1'b0; iss_rd = 5'd12;
        cycle();
        checks++;
        if (busy_vec !== 32'h0000_1200) begin
            errors++; $display("FAIL sb_reissue12: got %h expected 00001200", busy_vec);
        end
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0C0;
        cycle();
        checks++;
        if (busy_vec !== 32'h0000_0200) begin
            errors++; $display("FAIL sb_write_clear: got %h expected 00000200", busy_vec);
        end
        set_idle();
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        cycle();
        checks++;
        if (obs_alu_rdy !== 1'b1) begin
            errors++; $display("FAIL x0_ready: got %b expected 1", obs_alu_rdy);
        end
        checks++;
        if (rf_we !== 1'b0 || busy_vec !== 32'h0000_0200) begin
            errors++; $display("FAIL x0_write: got we=%b busy=%h expected 0 00000200", rf_we, busy_vec);
        end
        set_idle();
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (!alu_valid && ($urandom % 3 != 0)) begin
                alu_valid = 1'b1; alu_rd = REG_AW'($urandom); alu_data = $urandom;
            end
            if (!ld_valid && ($urandom % 2 == 0)) begin
                ld_valid = 1'b1; ld_rd = REG_AW'($urandom); ld_data = $urandom;
            end
            iss_valid = 1'($urandom % 2);
            iss_rd    = REG_AW'($urandom);
            flush     = ($urandom % 16 == 0);
            rst       = !($urandom % 80 == 0);
            cycle();
            checks++;
            if (obs_alu_rdy !== exp_alu_g || obs_ld_rdy !== exp_ld_g) begin
                errors++; $display("FAIL rnd_ready[%0d]: got alu=%b ld=%b expected alu=%b ld=%b", n, obs_alu_rdy, obs_ld_rdy, exp_alu_g, exp_ld_g);
            end
            checks++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                errors++; $display("FAIL rnd_rf[%0d]: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h", n, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
            checks++;
            if (busy_vec !== m_busy) begin
                errors++; $display("FAIL rnd_busy[%0d]: got %h expected %h", n, busy_vec, m_busy);
            end
            // Accepted requests retire; sometimes a new one follows immediately.
            if (exp_alu_g) begin
                alu_valid = 1'($urandom % 2);
                alu_rd = REG_AW'($urandom); alu_data = $urandom;
            end
            if (exp_ld_g) begin
                ld_valid = 1'($urandom % 2);
                ld_rd = REG_AW'($urandom); ld_data = $urandom;
            end
        end
        rst = 1'b1;
        set_idle();
        cycle();
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_conflict();
        test_starvation();
        test_scoreboard();
        test_x0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
